// File: rtl/maxpool_pkg.sv
// maxpool_pkg: definitions shared by the max-pool window scheduler.
//   state_t  - scheduler FSM state encoding
//   WIN_SIZE - pooling window edge length (windows are WIN_SIZE x WIN_SIZE)
package maxpool_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int WIN_SIZE = 3;

endpackage

// File: rtl/pool_valid_pipe.sv
// pool_valid_pipe: fixed-latency valid delay line that mirrors the max-pool
// datapath. The line shifts every cycle and ignores backpressure.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears the line)
//   in_valid  - window issued this cycle
//   out_valid - in_valid delayed by PIPE_LAT cycles
// PIPE_LAT must be at least 1.
module pool_valid_pipe #(
   parameter int PIPE_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic out_valid
);

   logic [PIPE_LAT-1:0] shift_q;
   logic [PIPE_LAT-1:0] shift_d;

   // Next contents of the delay line: new bit enters at index 0.
   always_comb begin
      shift_d    = shift_q;
      shift_d[0] = in_valid;
      for (int i = 1; i < PIPE_LAT; i++) begin
         shift_d[i] = shift_q[i-1];
      end
   end

   // Delay line register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign out_valid = shift_q[PIPE_LAT-1];

endmodule

// File: rtl/maxpool_sched.sv
// maxpool_sched: walks a 3x3 pooling window over an img_w x img_h feature map
// with step STRIDE, issuing one window origin per non-stalled cycle, then
// waits for the datapath to drain before pulsing done.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - begin a pass (ignored while busy)
//   img_w, img_h        - map dimensions, sampled when start is accepted
//   stall               - backpressure; freezes window issue
//   busy, done, err     - pass status; err is meaningful while done is high
//   win_valid           - window issued this cycle
//   win_row, win_col    - top-left origin of the issued window
//   out_valid           - win_valid delayed by PIPE_LAT cycles
//   out_count           - out_valid pulses in the current pass (saturating)
//   stall_cycles        - stalled RUN cycles (only with MAXPOOL_SCHED_PERF_EN)
// Build option: define MAXPOOL_SCHED_PERF_EN to add the stall_cycles counter.
module maxpool_sched
   import maxpool_pkg::*;
#(
   parameter int DIM_W    = 8,
   parameter int STRIDE   = 2,
   parameter int PIPE_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DIM_W-1:0] img_w,
   input  logic [DIM_W-1:0] img_h,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             win_valid,
   output logic [DIM_W-1:0] win_row,
   output logic [DIM_W-1:0] win_col,
   output logic             out_valid,
   output logic [15:0]      out_count
`ifdef MAXPOOL_SCHED_PERF_EN
   ,
   output logic [15:0]      stall_cycles
`endif
);

   // Two extra bits so origin + STRIDE + WIN_SIZE never overflows.
   localparam int SUM_W = DIM_W + 2;
   localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   state_t             state_q, state_d;
   logic [DIM_W-1:0]   img_w_q, img_w_d;
   logic [DIM_W-1:0]   img_h_q, img_h_d;
   logic [DIM_W-1:0]   row_q, row_d;
   logic [DIM_W-1:0]   col_q, col_d;
   logic               err_q, err_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [DRN_W-1:0]   drain_q, drain_d;
`ifdef MAXPOOL_SCHED_PERF_EN
   logic [15:0]        stall_q, stall_d;
`endif

   logic               bad_dims;
   logic               col_wrap;
   logic               row_wrap;
   logic               last_win;
   logic               pipe_out;

   assign bad_dims = (img_w < DIM_W'(WIN_SIZE)) || (img_h < DIM_W'(WIN_SIZE));
   // A coordinate wraps when the next window would no longer fit in the map.
   assign col_wrap = (SUM_W'(col_q) + SUM_W'(STRIDE + WIN_SIZE)) > SUM_W'(img_w_q);
   assign row_wrap = (SUM_W'(row_q) + SUM_W'(STRIDE + WIN_SIZE)) > SUM_W'(img_h_q);
   assign last_win = col_wrap && row_wrap;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = bad_dims ? ST_DONE : ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!stall && last_win) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRN_W'(PIPE_LAT - 1)) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      win_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         ST_IDLE:  busy      = 1'b0;
         ST_RUN:   win_valid = !stall;
         ST_DRAIN: busy      = 1'b1;
         ST_DONE:  done      = 1'b1;
         default:  busy      = 1'b0;
      endcase
   end

   // Coordinates, latched configuration, counters.
   always_comb begin
      img_w_d = img_w_q;
      img_h_d = img_h_q;
      row_d   = row_q;
      col_d   = col_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      drain_d = '0;
`ifdef MAXPOOL_SCHED_PERF_EN
      stall_d = stall_q;
`endif

      if (state_q == ST_DRAIN) begin
         drain_d = drain_q + DRN_W'(1);
      end else begin
         drain_d = '0;
      end

      // Coordinates hold on the final window so they stay in range.
      if (win_valid && !last_win) begin
         if (col_wrap) begin
            col_d = '0;
            row_d = row_q + DIM_W'(STRIDE);
         end else begin
            col_d = col_q + DIM_W'(STRIDE);
         end
      end else begin
         col_d = col_q;
      end

      if (pipe_out && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end

`ifdef MAXPOOL_SCHED_PERF_EN
      if ((state_q == ST_RUN) && stall && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end else begin
         stall_d = stall_q;
      end
`endif

      if ((state_q == ST_IDLE) && start) begin
`ifdef MAXPOOL_SCHED_PERF_EN
         stall_d = 16'd0;
`endif
         if (bad_dims) begin
            err_d = 1'b1;
         end else begin
            err_d   = 1'b0;
            img_w_d = img_w;
            img_h_d = img_h;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = 16'd0;
         end
      end else begin
         err_d = err_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         img_w_q <= '0;
         img_h_q <= '0;
         row_q   <= '0;
         col_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
         drain_q <= '0;
`ifdef MAXPOOL_SCHED_PERF_EN
         stall_q <= 16'd0;
`endif
      end else begin
         img_w_q <= img_w_d;
         img_h_q <= img_h_d;
         row_q   <= row_d;
         col_q   <= col_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
`ifdef MAXPOOL_SCHED_PERF_EN
         stall_q <= stall_d;
`endif
      end
   end

   pool_valid_pipe #(
      .PIPE_LAT (PIPE_LAT)
   ) u_valid_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (win_valid),
      .out_valid (pipe_out)
   );

   assign out_valid = pipe_out;
   assign out_count = cnt_q;
   assign err       = err_q;
   assign win_row   = row_q;
   assign win_col   = col_q;
`ifdef MAXPOOL_SCHED_PERF_EN
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_maxpool_sched.sv
// tb_maxpool_sched: scoreboard bench for maxpool_sched. The driver issues
// passes and pushes the expected window list (enumerated directly from the
// map size) plus the expected completion record; a monitor compares every
// cycle against those queues and the cycle-level timing rules.
module tb_maxpool_sched;

   localparam int DIM_W    = 8;
   localparam int STRIDE   = 2;
   localparam int PIPE_LAT = 4;

   typedef struct {int row; int col;} win_t;
   typedef struct {bit err; int nwin;} done_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [DIM_W-1:0] img_w;
   logic [DIM_W-1:0] img_h;
   logic             stall;
   logic             busy, done, err, win_valid, out_valid;
   logic [DIM_W-1:0] win_row, win_col;
   logic [15:0]      out_count;
`ifdef MAXPOOL_SCHED_PERF_EN
   logic [15:0]      stall_cycles;
`endif

   maxpool_sched #(
      .DIM_W    (DIM_W),
      .STRIDE   (STRIDE),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .img_w        (img_w),
      .img_h        (img_h),
      .stall        (stall),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .win_valid    (win_valid),
      .win_row      (win_row),
      .win_col      (win_col),
      .out_valid    (out_valid),
      .out_count    (out_count)
`ifdef MAXPOOL_SCHED_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   win_t  win_q[$];
   done_t done_q[$];
   int    ov_q[$];
   bit    pass_open = 1'b0;
   int    cur_start = 0;
   int    exp_done_cyc = -1;
   int    ov_seen = 0;
   int    stall_run = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_win_valid"}, win_valid, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_count"}, out_count, 0);
      chk({tag, "_win_row"}, win_row, 0);
      chk({tag, "_win_col"}, win_col, 0);
   endtask

   task automatic flush_model();
      win_q.delete();
      done_q.delete();
      ov_q.delete();
      pass_open    = 1'b0;
      exp_done_cyc = -1;
   endtask

   // Reference: enumerate every 3x3 window origin that fits in the map.
   task automatic issue(input int w, input int h);
      done_t d;
      d.err  = (w < 3) || (h < 3);
      d.nwin = 0;
      if (!d.err) begin
         for (int r = 0; r + 3 <= h; r += STRIDE) begin
            for (int c = 0; c + 3 <= w; c += STRIDE) begin
               win_t e;
               e.row = r;
               e.col = c;
               win_q.push_back(e);
               d.nwin++;
            end
         end
      end
      done_q.push_back(d);
      img_w     = w[DIM_W-1:0];
      img_h     = h[DIM_W-1:0];
      start     = 1'b1;
      stall     = 1'b0;
      cur_start = cyc;
      ov_seen   = 0;
      stall_run = 0;
      pass_open = 1'b1;
      exp_done_cyc = d.err ? cyc + 1 : -1;
   endtask

   // mode 0: no stall, 1: stall at cycles 2-3, 2: random stall, 3: restart attempt
   task automatic run_pass(input int w, input int h, input int mode);
      int budget;
      int rel;
      @(negedge clk);
      issue(w, h);
      budget = 0;
      while (pass_open && budget < 30000) begin
         @(negedge clk);
         start = 1'b0;
         budget++;
         rel = cyc - cur_start;
         case (mode)
            1: stall = (rel == 2) || (rel == 3);
            2: stall = ($urandom_range(0, 3) == 0);
            3: begin
               stall = 1'b0;
               if (rel == 2) begin
                  start = 1'b1;
                  img_w = 8'd15;
                  img_h = 8'd15;
               end
            end
            default: stall = 1'b0;
         endcase
      end
      if (pass_open) begin
         chk("pass_timeout", 1, 0);
         flush_model();
      end
      stall = 1'b0;
      start = 1'b0;
   endtask

   // Monitor: samples well before the rising edge.
   always @(negedge clk) begin
      #3;
      if (!rst) begin
         bit issuing;
         bit exp_wv;
         bit exp_ov;
         issuing = pass_open && (cyc > cur_start) && (win_q.size() > 0);
         exp_wv  = issuing && !stall;
         if (issuing && stall) stall_run++;

         if (win_valid || exp_wv) chk("win_valid", win_valid, exp_wv);
         if (win_valid && win_q.size() > 0) begin
            win_t e;
            e = win_q.pop_front();
            chk("win_row", win_row, e.row);
            chk("win_col", win_col, e.col);
            ov_q.push_back(cyc + PIPE_LAT);
            if (win_q.size() == 0) exp_done_cyc = cyc + PIPE_LAT + 1;
         end

         exp_ov = (ov_q.size() > 0) && (ov_q[0] == cyc);
         if (exp_ov) void'(ov_q.pop_front());
         if (out_valid || exp_ov) chk("out_valid", out_valid, exp_ov);
         if (out_valid) ov_seen++;

         chk("busy", busy, pass_open && (cyc > cur_start));

         if (done || (pass_open && cyc == exp_done_cyc))
            chk("done", done, pass_open && (cyc == exp_done_cyc));
         if (done && done_q.size() > 0) begin
            done_t d;
            d = done_q.pop_front();
            chk("err", err, d.err);
            if (!d.err) begin
               chk("out_pulses", ov_seen, d.nwin);
               chk("out_count", out_count, (d.nwin > 65535) ? 65535 : d.nwin);
            end
`ifdef MAXPOOL_SCHED_PERF_EN
            chk("stall_cycles", stall_cycles, stall_run);
`endif
            pass_open    = 1'b0;
            exp_done_cyc = -1;
         end
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      img_w = '0;
      img_h = '0;
      #2;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_pass(5, 5, 0);
      run_pass(7, 5, 1);
      run_pass(2, 9, 0);
      run_pass(9, 1, 0);
      run_pass(9, 7, 3);

      // Abort a pass mid-RUN with reset.
      @(negedge clk);
      issue(9, 9);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      #1;
      check_zero("abort");
      flush_model();
      @(negedge clk);
      rst = 1'b0;
      run_pass(9, 9, 0);

      for (int i = 0; i < 12; i++) begin
         run_pass($urandom_range(0, 20), $urandom_range(0, 20), 2);
      end
      run_pass(224, 224, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maxpool_sched.md
MAXPOOL_SCHED -- requirements
Module: maxpool_sched

Interface
REQ-001 Parameter: DIM_W, default 8, bit width of image dimension and window coordinate fields.
REQ-002 Parameter: STRIDE, default 2, window step in rows and columns; window size is fixed at 3x3.
REQ-003 Parameter: PIPE_LAT, default 4, max-pool datapath latency in cycles, from window valid to result valid.
REQ-004 Reset rst, asynchronous, active-high; clock clk.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a pooling pass.
REQ-008 img_w  in  DIM_W  feature-map width; sampled when start is accepted.
REQ-009 img_h  in  DIM_W  feature-map height; sampled when start is accepted.
REQ-010 stall  in  1  downstream backpressure; freezes window issue.
REQ-011 busy  out  1  high from start acceptance until the done pulse, inclusive.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  configuration error; valid while done is high.
REQ-014 win_valid  out  1  window issued to datapath this cycle.
REQ-015 win_row, win_col  out  DIM_W each  top-left origin of the issued window.
REQ-016 out_valid  out  1  win_valid delayed by PIPE_LAT cycles (datapath result valid).
REQ-017 out_count  out  16  number of out_valid pulses in the current pass.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-019 In IDLE with start=1: if img_w<3 or img_h<3, the block SHALL go to DONE with err=1; otherwise it SHALL latch the dimensions, clear out_count and err, and go to RUN.
REQ-020 In RUN with stall=0: win_valid=1 and the coordinates advance: win_col += STRIDE; when win_col+STRIDE+3 > img_w, win_col wraps to 0 and win_row += STRIDE.
REQ-021 The last window is the one where both the row and the column would wrap; after issuing it, the FSM SHALL enter DRAIN.
REQ-022 In RUN with stall=1: win_valid=0, and coordinates and state SHALL hold.
REQ-023 Outside RUN: win_valid=0.
REQ-024 The valid delay line SHALL shift every cycle regardless of stall.
REQ-025 DRAIN SHALL last exactly PIPE_LAT cycles, then go to DONE.
REQ-026 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in RUN, DRAIN, and DONE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 out_count SHALL increment on each out_valid and saturate at 16'hFFFF.

Reset
REQ-030 On rst, the block SHALL be in IDLE with all outputs 0, the delay line cleared, and coordinates 0.
REQ-031 An rst during RUN or DRAIN SHALL abort the pass with no done pulse; any in-flight valids are discarded.

Configuration
REQ-032 With MAXPOOL_SCHED_PERF_EN defined, output stall_cycles (16 bits) SHALL count RUN cycles with stall=1, saturate, reset to 0 on rst, and clear on start acceptance.
REQ-033 Without MAXPOOL_SCHED_PERF_EN, the stall_cycles port and its counter SHALL be absent.

Structure
REQ-034 A shared package maxpool_pkg SHALL hold the FSM state typedef and the window-size constant (3).
REQ-035 The valid delay line SHALL be a sub-module pool_valid_pipe, parameterised by PIPE_LAT.

Verification
REQ-036 5x5, no stall, start at cycle 0 -> win_valid in cycles 1-4 with origins (0,0),(0,2),(2,0),(2,2); out_valid in cycles 5-8; done at cycle 9; out_count=4.
REQ-037 7x5, stall high in cycles 2-3 -> 6 windows issued; coordinates frozen during the stall; done 2 cycles later than the no-stall case; stall_cycles=2 when PERF_EN is defined.
REQ-038 img_w=2 -> no win_valid; done with err=1 one cycle after start; busy high for that one cycle only.
REQ-039 start pulsed again during RUN -> ignored; the pass completes with the original dimensions.
REQ-040 rst asserted mid-RUN -> all outputs 0 immediately, no done pulse; a new start then runs a full pass correctly.
REQ-041 224x224 -> 111x111 = 12321 windows; final origin (220,220); out_count=12321.
